move_issuer: RTL and testbench

- Producer end of the move interface consumed by the game executioner.
- Accepts raw command bytes from the SPI byte receiver and decodes them into tetris_pkg::command_t.
- Buffers decoded commands in a small FIFO.
- Issues each command as a stable move/move_valid pair, qualified by a slow move_clk strobe. The strobe is slow enough to survive the consumer's 2-flop synchronizer and its use as a clock edge.

---
 rtl/tetris_pkg.sv | 42 ++++
 rtl/cmd_fifo.sv | 75 +++++++
 rtl/move_issuer.sv | 185 ++++++++++++++++++
 tb/tb_move_issuer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// ---------------------------------------------------------------------------
// tetris_pkg
// Shared definitions for the move interface between the SPI command path and
// the game executioner: command encoding, the sync nibble that marks a
// command byte, and the byte-to-command decoder used by both ends.
// ---------------------------------------------------------------------------
package tetris_pkg;

   typedef enum logic [2:0] {
      CMD_NONE   = 3'd0,
      CMD_LEFT   = 3'd1,
      CMD_RIGHT  = 3'd2,
      CMD_ROTATE = 3'd3,
      CMD_DROP   = 3'd4
   } command_t;

   localparam logic [3:0] CMD_SYNC_NIBBLE = 4'hA;

   typedef struct packed {
      logic     valid;
      command_t cmd;
   } decoded_cmd_t;

   // High nibble must be the sync nibble; low nibble selects the command.
   // Anything else decodes as invalid with CMD_NONE.
   function automatic decoded_cmd_t decode_cmd_byte(input logic [7:0] b);
      decoded_cmd_t r;
      r.valid = 1'b0;
      r.cmd   = CMD_NONE;
      if (b[7:4] == CMD_SYNC_NIBBLE) begin
         case (b[3:0])
            4'h1: begin r.valid = 1'b1; r.cmd = CMD_LEFT;   end
            4'h2: begin r.valid = 1'b1; r.cmd = CMD_RIGHT;  end
            4'h3: begin r.valid = 1'b1; r.cmd = CMD_ROTATE; end
            4'h4: begin r.valid = 1'b1; r.cmd = CMD_DROP;   end
            default: begin r.valid = 1'b0; r.cmd = CMD_NONE; end
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Small synchronous FIFO for decoded commands. Show-ahead: dout always
// presents the head entry, pop consumes it at the clock edge.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset (pointers/count only)
//   push, din   - write din when not full (or when full and popping)
//   pop, dout   - consume head entry; ignored when empty
//   count       - entries held (0..DEPTH)
//   full, empty - status derived from count
// ---------------------------------------------------------------------------
module cmd_fifo #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/move_issuer.sv
// ---------------------------------------------------------------------------
// move_issuer
// Producer end of the move interface. Decodes raw command bytes, queues
// them, and issues each one as a stable move/move_valid pair qualified by a
// slow move_clk strobe that the consumer synchronises and uses as an edge.
// Ports:
//   clk, reset       - clock, asynchronous active-low reset
//   cmd_byte         - raw byte from the SPI receiver
//   cmd_byte_valid   - one-cycle strobe qualifying cmd_byte
//   flags_clear      - synchronous clear of overflow/bad_cmd (a set wins)
//   move, move_valid - command being issued and its qualifier
//   move_clk         - issue strobe, registered
//   fifo_count       - commands queued
//   overflow         - sticky: valid command dropped on a full FIFO
//   bad_cmd          - sticky: undecodable byte received
// Slot timeline from SETUP entry: SETUP_CYCLES of setup, PULSE_CYCLES high,
// PULSE_CYCLES low, then GAP until ISSUE_INTERVAL cycles have passed.
// ---------------------------------------------------------------------------
module move_issuer
   import tetris_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned SETUP_CYCLES   = 2,
   parameter int unsigned PULSE_CYCLES   = 4,
   parameter int unsigned ISSUE_INTERVAL = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    cmd_byte,
   input  logic                          cmd_byte_valid,
   input  logic                          flags_clear,
   output logic [$bits(command_t)-1:0]   move,
   output logic                          move_valid,
   output logic                          move_clk,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          bad_cmd
);

   localparam int unsigned CMD_W      = $bits(command_t);
   localparam int unsigned GAP_CYCLES = ISSUE_INTERVAL - SETUP_CYCLES - 2 * PULSE_CYCLES;
   localparam int unsigned CNT_W      = $clog2(ISSUE_INTERVAL + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE_HI,
      ST_STROBE_LO,
      ST_GAP
   } issuer_state_t;

   issuer_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CMD_W-1:0] move_q, move_d;
   logic             move_valid_q, move_valid_d;
   logic             move_clk_q, move_clk_d;
   logic             overflow_q, overflow_d;
   logic             bad_cmd_q, bad_cmd_d;

   decoded_cmd_t     dec;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CMD_W-1:0] fifo_dout;
   logic             slot_end;

   assign dec       = decode_cmd_byte(cmd_byte);
   assign fifo_push = cmd_byte_valid & dec.valid;

   cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (dec.cmd),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Sticky flags: a new event in the same cycle as flags_clear keeps the flag set.
   always_comb begin
      overflow_d = (overflow_q & ~flags_clear) | (fifo_push & fifo_full & ~fifo_pop);
      bad_cmd_d  = (bad_cmd_q  & ~flags_clear) | (cmd_byte_valid & ~dec.valid);
   end

   // IDLE is treated as a permanently finished slot, so launching a command
   // from IDLE and back-to-back from the end of a slot share one path.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      move_d       = move_q;
      move_valid_d = move_valid_q;
      move_clk_d   = move_clk_q;
      fifo_pop     = 1'b0;
      slot_end     = 1'b0;

      case (state_q)
         ST_IDLE: slot_end = 1'b1;
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d    = ST_STROBE_HI;
               cnt_d      = CNT_W'(PULSE_CYCLES - 1);
               move_clk_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_STROBE_HI: begin
            if (cnt_q == '0) begin
               state_d    = ST_STROBE_LO;
               cnt_d      = CNT_W'(PULSE_CYCLES - 1);
               move_clk_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_STROBE_LO: begin
            if (cnt_q == '0) begin
               if (GAP_CYCLES == 0) begin
                  slot_end = 1'b1;
               end else begin
                  state_d      = ST_GAP;
                  cnt_d        = CNT_W'(GAP_CYCLES - 1);
                  move_valid_d = 1'b0;
                  move_d       = CMD_NONE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) slot_end = 1'b1;
            else             cnt_d    = cnt_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (slot_end) begin
         if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            state_d      = ST_SETUP;
            cnt_d        = CNT_W'(SETUP_CYCLES - 1);
            move_d       = fifo_dout;
            move_valid_d = 1'b1;
            move_clk_d   = 1'b0;
         end else begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            move_d       = CMD_NONE;
            move_valid_d = 1'b0;
            move_clk_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         move_q       <= CMD_NONE;
         move_valid_q <= 1'b0;
         move_clk_q   <= 1'b0;
         overflow_q   <= 1'b0;
         bad_cmd_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         move_q       <= move_d;
         move_valid_q <= move_valid_d;
         move_clk_q   <= move_clk_d;
         overflow_q   <= overflow_d;
         bad_cmd_q    <= bad_cmd_d;
      end
   end

   assign move       = move_q;
   assign move_valid = move_valid_q;
   assign move_clk   = move_clk_q;
   assign overflow   = overflow_q;
   assign bad_cmd    = bad_cmd_q;

endmodule

// File: tb/tb_move_issuer.sv
// ---------------------------------------------------------------------------
// tb_move_issuer
// Bench for move_issuer: a slot-age model predicts every output each cycle,
// directed scenarios pin timing with literal expectations, then random load.
// ---------------------------------------------------------------------------
module tb_move_issuer;

   localparam int DEPTH    = 4;
   localparam int SETUP    = 2;
   localparam int PULSE    = 4;
   localparam int INTERVAL = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] cmd_byte = 8'h00;
   logic       cmd_byte_valid = 1'b0;
   logic       flags_clear = 1'b0;
   logic [2:0] move;
   logic       move_valid, move_clk, overflow, bad_cmd;
   logic [2:0] fifo_count;

   move_issuer #(
      .FIFO_DEPTH     (DEPTH),
      .SETUP_CYCLES   (SETUP),
      .PULSE_CYCLES   (PULSE),
      .ISSUE_INTERVAL (INTERVAL)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .cmd_byte       (cmd_byte),
      .cmd_byte_valid (cmd_byte_valid),
      .flags_clear    (flags_clear),
      .move           (move),
      .move_valid     (move_valid),
      .move_clk       (move_clk),
      .fifo_count     (fifo_count),
      .overflow       (overflow),
      .bad_cmd        (bad_cmd)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endfunction

   // ---------------- behavioural model ----------------
   // A slot is identified by its age: edges elapsed since SETUP entry.
   logic [2:0] mq[$];
   bit         m_active = 1'b0;
   int         m_age = 0;
   logic [2:0] m_cmd = 3'd0;
   bit         m_ovf = 1'b0;
   bit         m_bad = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_active = 1'b0;
         m_age    = 0;
         m_cmd    = 3'd0;
         m_ovf    = 1'b0;
         m_bad    = 1'b0;
      end else begin
         int n;
         bit popped, ovf_ev, bad_ev, good;
         n = mq.size();
         popped = 1'b0;
         ovf_ev = 1'b0;
         bad_ev = 1'b0;
         if (m_active) begin
            if (m_age + 1 >= INTERVAL) m_active = 1'b0;
            else                       m_age++;
         end
         if (!m_active && n > 0) begin
            m_cmd    = mq.pop_front();
            m_active = 1'b1;
            m_age    = 0;
            popped   = 1'b1;
         end
         if (cmd_byte_valid) begin
            good = (cmd_byte[7:4] == 4'hA) && (cmd_byte[3:0] >= 4'd1) && (cmd_byte[3:0] <= 4'd4);
            if (!good)                        bad_ev = 1'b1;
            else if (n < DEPTH || popped)     mq.push_back(cmd_byte[2:0]);
            else                              ovf_ev = 1'b1;
         end
         m_ovf = (m_ovf && !flags_clear) || ovf_ev;
         m_bad = (m_bad && !flags_clear) || bad_ev;
      end
   end

   bit cmp_en = 1'b0;

   always @(negedge clk) begin
      if (cmp_en) begin
         bit ev, ec;
         ev = m_active && (m_age < SETUP + 2 * PULSE);
         ec = m_active && (m_age >= SETUP) && (m_age < SETUP + PULSE);
         check("model_move_valid", move_valid, ev);
         check("model_move_clk", move_clk, ec);
         check("model_move", move, ev ? m_cmd : 3'd0);
         check("model_fifo_count", fifo_count, mq.size());
         check("model_overflow", overflow, m_ovf);
         check("model_bad_cmd", bad_cmd, m_bad);
      end
   end

   // ---------------- strobe monitor ----------------
   int         rise_cyc[$];
   logic [2:0] rise_cmd[$];
   bit         prev_clk = 1'b0;
   int         peak = 0;

   always @(negedge clk) begin
      if (move_clk === 1'b1 && !prev_clk) begin
         rise_cyc.push_back(cyc);
         rise_cmd.push_back(move);
      end
      prev_clk = (move_clk === 1'b1);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
   end

   task automatic mon_clear();
      rise_cyc.delete();
      rise_cmd.delete();
      peak = 0;
   endtask

   // Inputs change on the falling edge and are sampled at the next rising edge.
   task automatic drive(input bit v, input logic [7:0] b, input bit clr);
      @(negedge clk);
      cmd_byte_valid = v;
      cmd_byte       = b;
      flags_clear    = clr;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((m_active || mq.size() != 0) && k < 600) begin
         drive(1'b0, 8'h00, 1'b0);
         k++;
      end
      check("wait_idle_bound", k < 600, 1);
      idle(2);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, c;
      logic [7:0] b;

      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_move", move, 0);
      check("reset_move_valid", move_valid, 0);
      check("reset_move_clk", move_clk, 0);
      check("reset_fifo_count", fifo_count, 0);
      check("reset_overflow", overflow, 0);
      check("reset_bad_cmd", bad_cmd, 0);
      #2 reset = 1'b1;
      cmp_en = 1'b1;
      idle(3);

      // Single command: literal timing relative to the accepting edge e.
      mon_clear();
      drive(1'b1, 8'hA1, 1'b0);
      e = cyc + 1;
      for (int i = 0; i < 26; i++) begin
         drive(1'b0, 8'h00, 1'b0);
         c = cyc;
         check("single_valid", move_valid, (c >= e + 1 && c <= e + 10));
         check("single_clk", move_clk, (c >= e + 3 && c <= e + 6));
         check("single_move", move, (c >= e + 1 && c <= e + 10) ? 3'd1 : 3'd0);
         if (c == e) check("single_count_after_push", fifo_count, 1);
      end

      // Back-to-back: three slots exactly one interval apart, in order.
      wait_idle();
      mon_clear();
      drive(1'b1, 8'hA2, 1'b0);
      e = cyc + 1;
      drive(1'b1, 8'hA3, 1'b0);
      drive(1'b1, 8'hA4, 1'b0);
      idle(60);
      check("b2b_strobes", rise_cyc.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check("b2b_rise_cycle", (i < rise_cyc.size()) ? rise_cyc[i] : -1, e + 3 + 16 * i);
         check("b2b_rise_cmd", (i < rise_cmd.size()) ? rise_cmd[i] : 3'd7, 2 + i);
      end
      check("b2b_peak_count", peak, 2);

      // Overflow: six bytes while busy, one dropped.
      wait_idle();
      mon_clear();
      repeat (6) drive(1'b1, 8'hA1, 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      check("ovf_set", overflow, 1);
      check("ovf_count_full", fifo_count, 4);
      idle(100);
      check("ovf_strobes", rise_cyc.size(), 5);
      check("ovf_peak_count", peak, 4);
      check("ovf_sticky", overflow, 1);
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
      check("ovf_cleared", overflow, 0);

      // Bad bytes: flagged, never queued or issued.
      wait_idle();
      mon_clear();
      drive(1'b1, 8'h51, 1'b0);
      drive(1'b1, 8'hA0, 1'b0);
      drive(1'b1, 8'hA7, 1'b0);
      idle(30);
      check("bad_set", bad_cmd, 1);
      check("bad_peak_count", peak, 0);
      check("bad_strobes", rise_cyc.size(), 0);
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
      check("bad_cleared", bad_cmd, 0);
      drive(1'b1, 8'h5A, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
      check("bad_set_wins_clear", bad_cmd, 1);
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
      check("bad_cleared_again", bad_cmd, 0);

      // Full FIFO with push and pop on the same edge (second SETUP entry).
      wait_idle();
      mon_clear();
      drive(1'b1, 8'hA1, 1'b0);
      e = cyc + 1;
      repeat (4) drive(1'b1, 8'hA1, 1'b0);
      while (cyc + 1 < e + 16) drive(1'b0, 8'h00, 1'b0);
      check("fullpp_before", fifo_count, 4);
      drive(1'b1, 8'hA2, 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      check("fullpp_count", fifo_count, 4);
      check("fullpp_no_overflow", overflow, 0);
      idle(120);
      check("fullpp_strobes", rise_cyc.size(), 6);
      check("fullpp_last_cmd", (rise_cmd.size() > 0) ? rise_cmd[rise_cmd.size() - 1] : 3'd7, 2);

      // Reset during STROBE_HI with commands queued.
      wait_idle();
      mon_clear();
      drive(1'b1, 8'hA3, 1'b0);
      e = cyc + 1;
      drive(1'b1, 8'hA1, 1'b0);
      drive(1'b1, 8'hA1, 1'b0);
      while (cyc < e + 4) drive(1'b0, 8'h00, 1'b0);
      check("midreset_pre_clk", move_clk, 1);
      check("midreset_pre_count", fifo_count, 2);
      #1 reset = 1'b0;
      #1;
      check("midreset_clk", move_clk, 0);
      check("midreset_valid", move_valid, 0);
      check("midreset_count", fifo_count, 0);
      check("midreset_move", move, 0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      for (int i = 0; i < 50; i++) begin
         drive(1'b0, 8'h00, 1'b0);
         check("postreset_idle", {move_clk, move_valid, fifo_count, move}, 0);
      end

      // Random load with one asynchronous reset in the middle.
      for (int i = 0; i < 3000; i++) begin
         if (($urandom % 5) == 0) b = 8'($urandom);
         else                     b = {4'hA, 4'($urandom_range(1, 4))};
         drive(($urandom % 3) == 0, b, ($urandom % 40) == 0);
         if (i == 1500) begin
            #2 reset = 1'b0;
            @(negedge clk);
            #2 reset = 1'b1;
         end
      end
      drive(1'b0, 8'h00, 1'b0);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
